// File: rtl/rpn_evaluator.sv
// rpn_evaluator: streaming reverse-Polish expression evaluator driving an
// external stack through push/pop commands.
// Optional feature macro RPN_MUL_EN: when defined, opcode 10 multiplies. When
// undefined, no multiplier is built and opcode 10 is reported as malformed.
module rpn_evaluator #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tok_valid,
  output logic              tok_ready,
  input  logic              tok_is_op,
  input  logic [DATA_W-1:0] tok_data,
  input  logic              tok_last,
  output logic              stk_push,
  output logic              stk_pop,
  output logic [DATA_W-1:0] stk_data_in,
  input  logic [DATA_W-1:0] stk_data_out,
  input  logic              stk_ready,
  input  logic              stk_valid,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [1:0]        res_err
);

  typedef enum logic [2:0] {
    ACCEPT, POP_A, EXEC, FINAL, CHECK, FLUSH, OUTPUT
  } state_t;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_UNDER = 2'b01;
  localparam logic [1:0] ERR_OVER  = 2'b10;
  localparam logic [1:0] ERR_MALF  = 2'b11;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_a, w_a_nxt;
  logic [DATA_W-1:0] r_b, w_b_nxt;
  logic [1:0]        r_op, w_op_nxt;
  logic [DATA_W-1:0] r_res, w_res_nxt;
  logic [1:0]        r_err, w_err_nxt;
  logic              r_last, w_last_nxt;
  logic              w_op_bad;

  // Arithmetic core; all results wrap modulo 2^DATA_W.
  function automatic logic [DATA_W-1:0] alu(input logic [1:0] op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] y;
    case (op)
      2'b00:   y = a + b;
      2'b01:   y = a - b;
`ifdef RPN_MUL_EN
      2'b10:   y = a * b;
`else
      2'b10:   y = '0;
`endif
      default: y = a & b;
    endcase
    return y;
  endfunction

  // The first error of an expression sticks; later ones are ignored.
  function automatic logic [1:0] first_err(input logic [1:0] cur,
                                           input logic [1:0] nxt);
    return (cur == ERR_OK) ? nxt : cur;
  endfunction

`ifdef RPN_MUL_EN
  assign w_op_bad = 1'b0;
`else
  assign w_op_bad = (tok_data[1:0] == 2'b10);
`endif

  // State and operand/result latches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ACCEPT;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= 2'b00;
      r_res   <= '0;
      r_err   <= ERR_OK;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_op    <= w_op_nxt;
      r_res   <= w_res_nxt;
      r_err   <= w_err_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Next-state logic and stack/token/result handshakes.
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_op_nxt    = r_op;
    w_res_nxt   = r_res;
    w_err_nxt   = r_err;
    w_last_nxt  = r_last;
    tok_ready   = 1'b0;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    stk_data_in = '0;
    res_valid   = 1'b0;
    res_data    = '0;
    res_err     = ERR_OK;
    case (r_state)
      ACCEPT: begin
        tok_ready = 1'b1;
        if (tok_valid) begin
          w_last_nxt = tok_last;
          if (!tok_is_op) begin
            if (stk_ready) begin
              stk_push    = 1'b1;
              stk_data_in = tok_data;
              w_state_nxt = tok_last ? FINAL : ACCEPT;
            end else begin
              w_err_nxt   = first_err(r_err, ERR_OVER);
              w_state_nxt = FLUSH;
            end
          end else if (w_op_bad) begin
            w_err_nxt   = first_err(r_err, ERR_MALF);
            w_state_nxt = FLUSH;
          end else if (stk_valid) begin
            w_b_nxt     = stk_data_out;
            w_op_nxt    = tok_data[1:0];
            stk_pop     = 1'b1;
            w_state_nxt = POP_A;
          end else begin
            w_err_nxt   = first_err(r_err, ERR_UNDER);
            w_state_nxt = FLUSH;
          end
        end
      end
      POP_A: begin
        if (stk_valid) begin
          w_a_nxt     = stk_data_out;
          stk_pop     = 1'b1;
          w_state_nxt = EXEC;
        end else begin
          w_err_nxt   = first_err(r_err, ERR_UNDER);
          w_state_nxt = FLUSH;
        end
      end
      EXEC: begin
        stk_push    = 1'b1;
        stk_data_in = alu(r_op, r_a, r_b);
        w_state_nxt = r_last ? FINAL : ACCEPT;
      end
      FINAL: begin
        if (stk_valid) begin
          w_res_nxt   = stk_data_out;
          stk_pop     = 1'b1;
          w_state_nxt = CHECK;
        end else begin
          w_err_nxt   = first_err(r_err, ERR_UNDER);
          w_state_nxt = OUTPUT;
        end
      end
      CHECK: begin
        if (stk_valid) begin
          w_err_nxt   = first_err(r_err, ERR_MALF);
          w_state_nxt = FLUSH;
        end else begin
          w_state_nxt = OUTPUT;
        end
      end
      FLUSH: begin
        // Drain the stack and swallow tokens until the expression's last one.
        tok_ready = !r_last;
        stk_pop   = stk_valid;
        if (tok_valid && !r_last && tok_last) w_last_nxt = 1'b1;
        if (!stk_valid && r_last) w_state_nxt = OUTPUT;
      end
      OUTPUT: begin
        res_valid = 1'b1;
        res_err   = r_err;
        res_data  = (r_err == ERR_OK) ? r_res : '0;
        if (res_ready) begin
          w_err_nxt   = ERR_OK;
          w_last_nxt  = 1'b0;
          w_res_nxt   = '0;
          w_state_nxt = ACCEPT;
        end
      end
      default: w_state_nxt = ACCEPT;
    endcase
  end

endmodule
